// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector.
// Consumes SYM_W stream bits per accepted cycle (din[0] oldest) and compares the
// running history against a runtime-loadable pattern of 1..PAT_MAX bits.
// Ports:
//   clk      - rising-edge clock
//   clr      - asynchronous active-high reset
//   din      - SYM_W stream bits, din[0] first in time
//   din_vld  - din consumed this cycle when high
//   cfg_ld   - load pat/pat_len/overlap into shadow registers (wins over din_vld)
//   pat      - pattern, bit [len-1] first received, bit [0] last
//   pat_len  - pattern length in bits
//   overlap  - 1: overlapping matches, 0: history flushed after each match
//   cnt_clr  - synchronous clear of det_cnt (wins over a coincident match)
//   det      - at least one match in the last accepted symbol
//   det_mask - bit i set when a match ended on din[i]
//   det_cnt  - saturating total match count
//   cfg_err  - loaded length illegal; matching disabled
module seq_detect_param #(
   parameter int unsigned SYM_W   = 2,
   parameter int unsigned PAT_MAX = 16,
   parameter int unsigned CNT_W   = 8,
   parameter logic [PAT_MAX-1:0] DEF_PAT = PAT_MAX'(5'b01110),
   parameter int unsigned DEF_LEN = 5,
   parameter bit          DEF_OVL = 1'b1,
   localparam int unsigned LEN_W  = $clog2(PAT_MAX + 1)
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [SYM_W-1:0]   din,
   input  logic               din_vld,
   input  logic               cfg_ld,
   input  logic [PAT_MAX-1:0] pat,
   input  logic [LEN_W-1:0]   pat_len,
   input  logic               overlap,
   input  logic               cnt_clr,
   output logic               det,
   output logic [SYM_W-1:0]   det_mask,
   output logic [CNT_W-1:0]   det_cnt,
   output logic               cfg_err
);

   localparam int unsigned SUM_W = CNT_W + $clog2(SYM_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [PAT_MAX-1:0] pat_q,  pat_d;
   logic [LEN_W-1:0]   len_q,  len_d;
   logic               ovl_q,  ovl_d;
   logic               err_q,  err_d;
   logic [PAT_MAX-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic [SYM_W-1:0]   mask_q, mask_d;
   logic               det_q,  det_d;
   logic [CNT_W-1:0]   cnt_q,  cnt_d;

   // Serial scan of the symbol plus next-state selection
   logic [PAT_MAX-1:0] hist_w;
   logic [LEN_W-1:0]   fill_w;
   logic [SYM_W-1:0]   mask_w;
   logic [PAT_MAX-1:0] len_mask;
   logic [SUM_W-1:0]   sum;

   always_comb begin
      pat_d  = pat_q;
      len_d  = len_q;
      ovl_d  = ovl_q;
      err_d  = err_q;
      hist_d = hist_q;
      fill_d = fill_q;
      mask_d = '0;
      det_d  = 1'b0;
      cnt_d  = cnt_q;
      hist_w = hist_q;
      fill_w = fill_q;
      mask_w = '0;
      sum    = '0;

      // Ones in bits [len-1:0]; a shift by PAT_MAX leaves the whole word enabled
      len_mask = ~({PAT_MAX{1'b1}} << len_q);

      for (int i = 0; i < SYM_W; i++) begin
         hist_w = {hist_w[PAT_MAX-2:0], din[i]};
         if (fill_w < LEN_W'(PAT_MAX)) begin
            fill_w = fill_w + LEN_W'(1);
         end
         if (!err_q && (fill_w >= len_q) &&
             (((hist_w ^ pat_q) & len_mask) == '0)) begin
            mask_w[i] = 1'b1;
            // Non-overlap: later bits of this symbol start a fresh search
            if (!ovl_q) begin
               fill_w = '0;
            end
         end
      end

      if (cfg_ld) begin
         pat_d  = pat;
         len_d  = pat_len;
         ovl_d  = overlap;
         err_d  = (pat_len == '0) || (pat_len > LEN_W'(PAT_MAX));
         hist_d = '0;
         fill_d = '0;
      end else if (din_vld) begin
         hist_d = hist_w;
         fill_d = fill_w;
         mask_d = mask_w;
      end

      det_d = |mask_d;

      // Saturating add of this symbol's match count; clear takes priority
      sum = SUM_W'(cnt_q);
      for (int i = 0; i < SYM_W; i++) begin
         sum = sum + SUM_W'(mask_d[i]);
      end
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (sum > SUM_W'(CNT_MAX)) begin
         cnt_d = CNT_MAX;
      end else begin
         cnt_d = sum[CNT_W-1:0];
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pat_q  <= DEF_PAT;
         len_q  <= LEN_W'(DEF_LEN);
         ovl_q  <= DEF_OVL;
         err_q  <= 1'b0;
         hist_q <= '0;
         fill_q <= '0;
         mask_q <= '0;
         det_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         pat_q  <= pat_d;
         len_q  <= len_d;
         ovl_q  <= ovl_d;
         err_q  <= err_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         mask_q <= mask_d;
         det_q  <= det_d;
         cnt_q  <= cnt_d;
      end
   end

   assign det      = det_q;
   assign det_mask = mask_q;
   assign det_cnt  = cnt_q;
   assign cfg_err  = err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a 2-bit-symbol instance with a 4-bit
// counter for most scenarios, plus a 4-bit-symbol instance for multi-match.
module tb_seq_detect_param;

   logic        clk;
   logic        clr;

   logic [1:0]  din;
   logic        din_vld;
   logic        cfg_ld;
   logic [15:0] pat;
   logic [4:0]  pat_len;
   logic        overlap;
   logic        cnt_clr;
   logic        det;
   logic [1:0]  det_mask;
   logic [3:0]  det_cnt;
   logic        cfg_err;

   logic [3:0]  din4;
   logic        din_vld4;
   logic        cfg_ld4;
   logic [15:0] pat4;
   logic [4:0]  pat_len4;
   logic        overlap4;
   logic        cnt_clr4;
   logic        det4;
   logic [3:0]  det_mask4;
   logic [7:0]  det_cnt4;
   logic        cfg_err4;

   int n_pass;
   int n_total;

   seq_detect_param #(.SYM_W(2), .PAT_MAX(16), .CNT_W(4)) u_dut (
      .clk      (clk),
      .clr      (clr),
      .din      (din),
      .din_vld  (din_vld),
      .cfg_ld   (cfg_ld),
      .pat      (pat),
      .pat_len  (pat_len),
      .overlap  (overlap),
      .cnt_clr  (cnt_clr),
      .det      (det),
      .det_mask (det_mask),
      .det_cnt  (det_cnt),
      .cfg_err  (cfg_err)
   );

   seq_detect_param #(.SYM_W(4), .PAT_MAX(16), .CNT_W(8)) u_dut4 (
      .clk      (clk),
      .clr      (clr),
      .din      (din4),
      .din_vld  (din_vld4),
      .cfg_ld   (cfg_ld4),
      .pat      (pat4),
      .pat_len  (pat_len4),
      .overlap  (overlap4),
      .cnt_clr  (cnt_clr4),
      .det      (det4),
      .det_mask (det_mask4),
      .det_cnt  (det_cnt4),
      .cfg_err  (cfg_err4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock on the 2-bit instance; outputs are sampled 1 time unit after the edge
   task automatic drv(input logic [1:0] d, input logic v, input logic ld,
                      input logic [15:0] p, input logic [4:0] l, input logic o,
                      input logic cc);
      din     = d;
      din_vld = v;
      cfg_ld  = ld;
      pat     = p;
      pat_len = l;
      overlap = o;
      cnt_clr = cc;
      @(posedge clk);
      #1;
      din_vld = 1'b0;
      cfg_ld  = 1'b0;
      cnt_clr = 1'b0;
   endtask

   task automatic sym(input logic [1:0] d);
      drv(d, 1'b1, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic load(input logic [15:0] p, input logic [4:0] l, input logic o,
                       input logic cc);
      drv(2'b00, 1'b0, 1'b1, p, l, o, cc);
   endtask

   initial begin
      n_pass   = 0;
      n_total  = 0;
      clr      = 1'b1;
      din      = '0;
      din_vld  = 1'b0;
      cfg_ld   = 1'b0;
      pat      = '0;
      pat_len  = '0;
      overlap  = 1'b0;
      cnt_clr  = 1'b0;
      din4     = '0;
      din_vld4 = 1'b0;
      cfg_ld4  = 1'b0;
      pat4     = '0;
      pat_len4 = '0;
      overlap4 = 1'b0;
      cnt_clr4 = 1'b0;

      // Reset state
      @(posedge clk);
      #1;
      chk("rst_det", 32'(det), 32'd0);
      chk("rst_mask", 32'(det_mask), 32'd0);
      chk("rst_cnt", 32'(det_cnt), 32'd0);
      chk("rst_err", 32'(cfg_err), 32'd0);
      clr = 1'b0;

      // Default pattern 01110: stream 0,1,1,1,0,0
      sym(2'b10);
      chk("def_s1_mask", 32'(det_mask), 32'd0);
      sym(2'b11);
      chk("def_s2_mask", 32'(det_mask), 32'd0);
      sym(2'b00);
      chk("def_s3_mask", 32'(det_mask), 32'b01);
      chk("def_s3_det", 32'(det), 32'd1);
      chk("def_s3_cnt", 32'(det_cnt), 32'd1);
      drv(2'b00, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0);
      chk("def_idle_det", 32'(det), 32'd0);
      chk("def_idle_cnt", 32'(det_cnt), 32'd1);

      // Pattern 101, overlapping: stream 1,0,1,0,1,0
      load(16'b101, 5'd3, 1'b1, 1'b1);
      chk("ovl_ld_cnt", 32'(det_cnt), 32'd0);
      sym(2'b01);
      chk("ovl_s1_mask", 32'(det_mask), 32'b00);
      sym(2'b01);
      chk("ovl_s2_mask", 32'(det_mask), 32'b01);
      sym(2'b01);
      chk("ovl_s3_mask", 32'(det_mask), 32'b01);
      chk("ovl_cnt", 32'(det_cnt), 32'd2);

      // Same stream, non-overlapping
      load(16'b101, 5'd3, 1'b0, 1'b1);
      sym(2'b01);
      chk("novl_s1_mask", 32'(det_mask), 32'b00);
      sym(2'b01);
      chk("novl_s2_mask", 32'(det_mask), 32'b01);
      sym(2'b01);
      chk("novl_s3_mask", 32'(det_mask), 32'b00);
      chk("novl_cnt", 32'(det_cnt), 32'd1);

      // Saturation: pattern '1', two matches per symbol, 4-bit counter
      load(16'b1, 5'd1, 1'b1, 1'b1);
      for (int k = 1; k <= 9; k++) begin
         sym(2'b11);
         if (k == 7) chk("sat_k7_cnt", 32'(det_cnt), 32'd14);
         if (k == 8) chk("sat_k8_cnt", 32'(det_cnt), 32'd15);
      end
      chk("sat_k9_cnt", 32'(det_cnt), 32'd15);
      chk("sat_k9_mask", 32'(det_mask), 32'b11);
      drv(2'b11, 1'b1, 1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
      chk("cclr_cnt", 32'(det_cnt), 32'd0);
      chk("cclr_mask", 32'(det_mask), 32'b11);
      chk("cclr_det", 32'(det), 32'd1);
      sym(2'b11);
      chk("post_cclr_cnt", 32'(det_cnt), 32'd2);

      // Config load beats a completing symbol and clears history
      load(16'b01110, 5'd5, 1'b1, 1'b0);
      chk("prio_ld_cnt", 32'(det_cnt), 32'd2);
      sym(2'b10);
      sym(2'b11);
      chk("prio_pre_mask", 32'(det_mask), 32'b00);
      drv(2'b00, 1'b1, 1'b1, 16'b01110, 5'd5, 1'b1, 1'b0);
      chk("prio_drop_mask", 32'(det_mask), 32'b00);
      chk("prio_drop_det", 32'(det), 32'd0);
      sym(2'b10);
      chk("prio_hclr_mask", 32'(det_mask), 32'b00);
      sym(2'b11);
      chk("prio_s2_mask", 32'(det_mask), 32'b00);
      sym(2'b00);
      chk("prio_s3_mask", 32'(det_mask), 32'b01);
      chk("prio_cnt", 32'(det_cnt), 32'd3);

      // Illegal lengths
      load(16'h0, 5'd0, 1'b1, 1'b0);
      chk("len0_err", 32'(cfg_err), 32'd1);
      sym(2'b10);
      chk("len0_s1_mask", 32'(det_mask), 32'b00);
      sym(2'b11);
      chk("len0_s2_mask", 32'(det_mask), 32'b00);
      sym(2'b00);
      chk("len0_s3_det", 32'(det), 32'd0);
      chk("len0_cnt", 32'(det_cnt), 32'd3);
      load(16'b01110, 5'd17, 1'b1, 1'b0);
      chk("len17_err", 32'(cfg_err), 32'd1);
      load(16'b01110, 5'd16, 1'b1, 1'b0);
      chk("len16_err", 32'(cfg_err), 32'd0);
      load(16'b01110, 5'd5, 1'b1, 1'b0);
      chk("len5_err", 32'(cfg_err), 32'd0);
      sym(2'b10);
      sym(2'b11);
      sym(2'b00);
      chk("len5_mask", 32'(det_mask), 32'b01);
      chk("len5_cnt", 32'(det_cnt), 32'd4);

      // Asynchronous reset between edges restores defaults and flushes history
      load(16'b1, 5'd1, 1'b0, 1'b0);
      sym(2'b11);
      chk("pre_rst_cnt", 32'(det_cnt), 32'd6);
      chk("pre_rst_mask", 32'(det_mask), 32'b11);
      #3;
      clr = 1'b1;
      #1;
      chk("arst_det", 32'(det), 32'd0);
      chk("arst_mask", 32'(det_mask), 32'd0);
      chk("arst_cnt", 32'(det_cnt), 32'd0);
      clr = 1'b0;
      sym(2'b00);
      chk("arst_s1_mask", 32'(det_mask), 32'b00);
      sym(2'b10);
      chk("arst_s2_mask", 32'(det_mask), 32'b00);
      sym(2'b11);
      chk("arst_s3_mask", 32'(det_mask), 32'b00);
      sym(2'b00);
      chk("arst_s4_mask", 32'(det_mask), 32'b01);
      chk("arst_cnt_end", 32'(det_cnt), 32'd1);

      // Four-bit symbols: several matches in one symbol
      cfg_ld4  = 1'b1;
      pat4     = 16'b1;
      pat_len4 = 5'd1;
      overlap4 = 1'b1;
      @(posedge clk);
      #1;
      cfg_ld4  = 1'b0;
      din4     = 4'b1011;
      din_vld4 = 1'b1;
      @(posedge clk);
      #1;
      din_vld4 = 1'b0;
      chk("w4_mask", 32'(det_mask4), 32'b1011);
      chk("w4_det", 32'(det4), 32'd1);
      chk("w4_cnt", 32'(det_cnt4), 32'd3);
      @(posedge clk);
      #1;
      chk("w4_idle_det", 32'(det4), 32'd0);
      chk("w4_idle_mask", 32'(det_mask4), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parameterised serial pattern detector. Generalises the fixed 5-bit, 2-bit-per-clock detector of the seq_detect family.
- Accepts SYM_W stream bits per valid cycle and matches a runtime-loadable pattern of 1..PAT_MAX bits.
- Supports overlapping or non-overlapping detection, reports every match position within the symbol, and keeps a saturating match counter.
- Sits between the serial front-end and the event/interrupt logic.

Parameters:
- SYM_W, 2: stream bits consumed per accepted cycle; din[0] is the oldest bit.
- PAT_MAX, 16: maximum pattern length in bits.
- CNT_W, 8: width of the match counter.
- DEF_PAT, 16'b01110: pattern loaded at reset. Bit [len-1] is the first bit received, bit [0] the last.
- DEF_LEN, 5: pattern length loaded at reset.
- DEF_OVL, 1: overlap mode loaded at reset.

Ports:
- clk  in  1  clock; all logic on rising edge.
- clr  in  1  asynchronous reset, active-high.
- din  in  SYM_W  stream bits; din[0] first in time.
- din_vld  in  1  din is consumed this cycle when high.
- cfg_ld  in  1  load pat/pat_len/overlap into the shadow registers.
- pat  in  PAT_MAX  pattern, MSB-first within pat_len.
- pat_len  in  clog2(PAT_MAX+1)  pattern length.
- overlap  in  1  1 = overlapping matches, 0 = history flush after each match.
- cnt_clr  in  1  synchronous clear of det_cnt.
- det  out  1  at least one match in the last accepted symbol.
- det_mask  out  SYM_W  bit i set = match ended on din[i].
- det_cnt  out  CNT_W  saturating total match count.
- cfg_err  out  1  active length is illegal; detection disabled.

Behaviour:
- Reset (clr=1, asynchronous):
  - Outputs: det=0, det_mask=0, det_cnt=0, cfg_err=0.
  - Internal: history=0, fill=0.
  - Shadow registers: pattern=DEF_PAT, length=DEF_LEN, overlap=DEF_OVL.
  - Reset mid-stream discards the partial history.
- Internal state:
  - hist: PAT_MAX-bit shift register; each new bit enters the LSB.
  - fill: count of valid history bits, saturating at PAT_MAX.
- Per accepted cycle (din_vld=1, cfg_ld=0), bits are processed serially in combinational logic, i = 0..SYM_W-1:
  - Shift din[i] into the running history and increment fill (saturating).
  - Match at position i when fill >= len and history[len-1:0] == pat[len-1:0]. On a match, set mask bit i.
  - On a match with overlap=0, reset fill to 0 before bit i+1. Bits after the match in the same symbol start a fresh search.
  - With overlap=1, fill is untouched by a match.
- Output timing:
  - det_mask and det are registered and appear one cycle after the accepted symbol (latency 1).
  - det = |det_mask.
  - det and det_mask return to 0 on any cycle without an accepted symbol.
- Counter:
  - det_cnt += popcount(det_mask), updated in the same cycle det_mask is registered.
  - Saturates at 2^CNT_W-1 with no wrap.
  - If cnt_clr coincides with a match, the clear wins and det_cnt=0 (the match is not counted).
  - det_mask is still reported when cnt_clr wins.
- Configuration load (cfg_ld=1):
  - Shadow registers load next edge; hist and fill are cleared; det and det_mask go to 0.
  - A simultaneous din_vld symbol is dropped; cfg_ld has priority.
  - det_cnt is unaffected.
- Illegal length:
  - pat_len=0 or pat_len>PAT_MAX sets cfg_err=1 (registered with the load).
  - While cfg_err=1, no matches occur, det_mask stays 0, and history still shifts.
  - A legal cfg_ld clears cfg_err.
- Implementation constraints:
  - History compare uses a variable-length mask derived from the registered length; bits above len are ignored.
  - Pattern and input X-free is required; no casex.

Test Plan:
- Reset defaults (01110, len5, overlap), SYM_W=2: symbols din=2'b10, 2'b11, 2'b00 (stream 0,1,1,1,0) -> cycle after third symbol: det_mask=2'b01, det=1, det_cnt=1; next idle cycle det=0.
- Overlap: cfg_ld pat=3'b101, len=3, overlap=1; din=2'b01, 2'b01, 2'b01 (stream 1,0,1,0,1,0) -> det_mask 00, 01, 01; det_cnt=2. Same stream with overlap=0 -> det_mask 00, 01, 00; det_cnt=1.
- Multi-match per symbol: SYM_W=4, pat=1'b1, len=1; din=4'b1011 -> det_mask=4'b1011, det_cnt=3.
- Saturation and clear: CNT_W=4, pattern len1=1, din all ones, SYM_W=2 for 9 cycles -> det_cnt sticks at 15. Then cnt_clr=1 with a matching symbol -> det_cnt=0, det_mask=2'b11.
- Config priority: mid-pattern (after stream 0,1,1) assert cfg_ld with din_vld and the completing symbol -> symbol dropped, no det, hist cleared. The following 0,1,1,1,0 is detected.
- Illegal length: cfg_ld pat_len=0 -> cfg_err=1, no det on any stream. Reload len=5 -> cfg_err=0 and detection resumes.
- Async reset: assert clr between edges mid-stream -> outputs 0 immediately. After release, the stream needs the full 5 new bits before det.
